multi_digit_display: RTL

Parametrised successor to the two-digit display driver for the 100 MHz board clock. It converts an unsigned binary value to BCD with a sequential double-dabble engine and a load/busy handshake. It then time-multiplexes DIGITS common-anode seven-segment digits. Overflow is shown as dashes, and an optional leading-zero blanking mode is available. It sits between datapath logic producing a binary count and the board's segment/anode pins.

---
 rtl/multi_digit_display.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/multi_digit_display.sv
// rtl/multi_digit_display.sv - binary to BCD converter with multiplexed seven-segment scan
//
// Converts an unsigned binary Number to BCD with a sequential double-dabble
// engine (Load/Busy handshake), then scans DIGITS common-anode digits.
// Values above 10^DIGITS-1 are shown as dashes on every digit.
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   defined   -> leading zero digits are dark (digit 0 always shown)
//   undefined -> every digit is shown
//
// Ports:
//   Clk     in   rising-edge system clock
//   Reset   in   asynchronous active-high reset
//   Number  in   [WIDTH-1:0] unsigned value to convert
//   Load    in   start a conversion; honoured only while Busy=0
//   Blank   in   all digits dark while high; scanning keeps running
//   Busy    out  conversion in progress
//   out7    out  [6:0] segments a..g, active low, registered
//   en_out  out  [DIGITS-1:0] digit enables, active low one-hot, registered
module multi_digit_display #(
    parameter int DIGITS       = 4,
    parameter int WIDTH        = 14,
    parameter int REFRESH_BITS = 18
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [WIDTH-1:0]  Number,
    input  logic              Load,
    input  logic              Blank,
    output logic              Busy,
    output logic [6:0]        out7,
    output logic [DIGITS-1:0] en_out
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [63:0] MAX_VAL = 64'(10 ** DIGITS) - 64'd1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                  state;
    logic [WIDTH-1:0]        bin_sr;
    logic [BCD_W-1:0]        bcd_sr;
    logic [BCD_W-1:0]        bcd_adj;
    logic [BCD_W-1:0]        disp_bcd;
    logic                    ovf_cap;
    logic                    disp_ovf;
    logic [CNT_W-1:0]        iter;
    logic [REFRESH_BITS-1:0] dwell;
    logic [IDX_W-1:0]        idx;
    logic [3:0]              nib;
    logic                    lz_blank;
    logic [6:0]              seg_dec;

    // Double-dabble correction: any nibble >= 5 would exceed 9 after the shift.
    always_comb begin
        bcd_adj = bcd_sr;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_sr[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
        end
    end

    // Converter. The display register is only written on completion so a
    // half-converted value never reaches the segments.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            Busy     <= 1'b0;
            bin_sr   <= '0;
            bcd_sr   <= '0;
            iter     <= '0;
            ovf_cap  <= 1'b0;
            disp_bcd <= '0;
            disp_ovf <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Load) begin
                        bin_sr  <= Number;
                        bcd_sr  <= '0;
                        ovf_cap <= (64'(Number) > MAX_VAL);
                        iter    <= '0;
                        Busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (iter == CNT_W'(WIDTH)) begin
                        disp_bcd <= bcd_sr;
                        disp_ovf <= ovf_cap;
                        Busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        bcd_sr <= {bcd_adj[BCD_W-2:0], bin_sr[WIDTH-1]};
                        bin_sr <= bin_sr << 1;
                        iter   <= iter + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Scan: each digit dwells 2^REFRESH_BITS cycles.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            dwell <= '0;
            idx   <= '0;
        end else begin
            dwell <= dwell + 1'b1;
            if (&dwell)
                idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
        end
    end

    // Select the nibble for the current digit and decide leading-zero blanking.
    always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
        logic upper_zero;
        upper_zero = 1'b1;
`endif
        nib      = 4'd0;
        lz_blank = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
`ifdef LEADING_ZERO_BLANK_EN
            upper_zero = upper_zero && (disp_bcd[4*i +: 4] == 4'd0);
`endif
            if (idx == IDX_W'(i)) begin
                nib = disp_bcd[4*i +: 4];
`ifdef LEADING_ZERO_BLANK_EN
                lz_blank = upper_zero && (i != 0);
`endif
            end
        end
    end

    always_comb begin
        case (nib)
            4'd0:    seg_dec = 7'b0000001;
            4'd1:    seg_dec = 7'b1001111;
            4'd2:    seg_dec = 7'b0010010;
            4'd3:    seg_dec = 7'b0000110;
            4'd4:    seg_dec = 7'b1001100;
            4'd5:    seg_dec = 7'b0100100;
            4'd6:    seg_dec = 7'b0100000;
            4'd7:    seg_dec = 7'b0001111;
            4'd8:    seg_dec = 7'b0000000;
            4'd9:    seg_dec = 7'b0000100;
            default: seg_dec = 7'b1111111;
        endcase
    end

    // Registered pin drivers; en_out goes straight from one one-hot value to
    // the next because it is a single register load.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            en_out <= '1;
            out7   <= 7'b1111111;
        end else if (Blank) begin
            en_out <= '1;
            out7   <= 7'b1111111;
        end else begin
            en_out <= ~(DIGITS'(1) << idx);
            if (disp_ovf)
                out7 <= 7'b1111110;
            else if (lz_blank)
                out7 <= 7'b1111111;
            else
                out7 <= seg_dec;
        end
    end

endmodule
